slc3_mem_responder: RTL and testbench
=====================================

# slc3_mem_responder

Memory-side responder for the SLC-3 datapath: it answers the controller's Mem_OE and Mem_WE strobes against on-chip synchronous block RAM with a registered output, plus a memory-mapped switch/hex port at xFFFF. After reset it preloads program RAM from an external ROM before serving any request. It sits between the datapath's MAR/MDR and the board I/O, and fixes the read latency that the controller's wait states are sized against.

## Interface
- DEPTH_BITS, 8: RAM address width; the RAM holds 2^DEPTH_BITS 16-bit words.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Mem_OE  in  1  read strobe from the controller.
- Mem_WE  in  1  write strobe from the controller.
- ADDR  in  16  word address (MAR).
- Data_from_CPU  in  16  write data (MDR).
- Data_to_CPU  out  16  read data.
- Rd_valid  out  1  Data_to_CPU holds the result of a read issued 2 cycles earlier.
- SW  in  16  board switches, readable at xFFFF.
- HEX_Data  out  16  hex-display register, written at xFFFF.
- Rom_addr  out  DEPTH_BITS  init ROM address.
- Rom_data  in  16  init ROM data, valid 1 cycle after Rom_addr.
- Init_busy  out  1  high while preloading; all requests are ignored.

## Operation
- **Reset values:** Data_to_CPU=0, Rd_valid=0, HEX_Data=0, Rom_addr=0, Init_busy=1. The init FSM enters INIT_FILL and the read pipe is cleared.
- **Init FSM states:**
  - INIT_FILL: drive Rom_addr=cnt. From cnt≥1, write Rom_data into RAM[cnt-1]. Increment cnt. After cnt=2^DEPTH_BITS-1, go to INIT_LAST.
  - INIT_LAST: write Rom_data into RAM[last]. Go to READY.
  - READY: serve requests; Init_busy=0. READY is left only by Reset.
- **Read:**
  - A cycle with Mem_OE=1, Mem_WE=0, Init_busy=0 issues a read of ADDR.
  - For RAM addresses, only ADDR[DEPTH_BITS-1:0] is used; higher bits alias.
  - ADDR=xFFFF selects SW instead of RAM. SW is sampled at issue and carried through the same 2-stage pipe, so latency is identical.
- **Write:**
  - A cycle with Mem_WE=1 and Init_busy=0 writes Data_from_CPU at the closing edge.
  - ADDR=xFFFF updates HEX_Data only; RAM is untouched.
- **Simultaneous Mem_OE and Mem_WE:** the write wins and no read is issued.
- **Pipelining:** reads are fully pipelined at 1 per cycle. Each issue cycle yields exactly one Rd_valid pulse.
- **Data hold:** Data_to_CPU holds its last value while Rd_valid=0.
- **Requests during init:** strobes are ignored, not queued. Rd_valid stays 0 and RAM/HEX are not written.
- **Reset mid-init or mid-read:** init restarts from cnt=0 and in-flight reads are discarded (no Rd_valid).

## Timing
- **Read latency:** issue in cycle T (address sampled at the end of T). RAM output register loads at the end of T+1. Data_to_CPU and Rd_valid are valid during T+2.
- **Controller match:** this fits a controller holding Mem_OE for 3 cycles and loading MDR each cycle. The MDR load at the end of the third cycle captures correct data.
- **Write:** takes effect at the edge ending the WE cycle.
- **Read-after-write:** a read issued in the cycle after a write to the same address returns the new data.
- **Same-cycle read/write:** a read and write to the same address in one cycle cannot occur (the write wins).
- **Init duration:** 2^DEPTH_BITS+1 cycles after Reset deasserts; Init_busy falls on the following edge.

## Structure
- **Package slc3_mem_pkg:**
  - MMIO_SW_HEX_ADDR=16'hFFFF
  - RD_LATENCY=2
  - init FSM enum {INIT_FILL, INIT_LAST, READY}
- **Sub-module slc3_bram:** single-port synchronous RAM with a registered output (2-cycle read). It contains no reset on the array. Top level holds the init FSM, address decode, MMIO registers, SW pipe and valid pipe.

## Test plan
- **Preload:** Reset with ROM[k]=k^x00A5, DEPTH_BITS=8. Expect Init_busy=1 for 257 cycles after Reset falls. Then reads of x0000 and x00FF return x00A5 and x005A, with Rd_valid exactly 2 cycles after issue.
- **Controller-style read:** Mem_OE held 3 cycles at x0010 (ROM x0010^x00A5=x00B5). Expect Data_to_CPU=x00B5 in cycle 3, and 3 Rd_valid pulses from cycles 3-5.
- **MMIO:**
  - WE at xFFFF with x1234 → HEX_Data=x1234 on the next edge, and RAM[xFF] is unchanged.
  - SW=xBEEF, read xFFFF → xBEEF after 2 cycles.
- **Write/read interaction:**
  - WE x0020←xCAFE, then OE x0020 in the next cycle → xCAFE.
  - OE+WE in the same cycle at x0021 → write happens and no Rd_valid.
- **Aliasing:** write x0105←x7777, then read x0005 → x7777.
- **Requests during init, and reset mid-init:**
  - OE/WE pulses during init are ignored (no Rd_valid, HEX_Data stays 0).
  - Reset asserted at cnt=100 → Rom_addr returns to 0 and the full 257-cycle init reruns.

Source files
------------

// File: rtl/slc3_mem_pkg.sv
// Shared constants and types for the SLC-3 memory responder.
// Holds the MMIO address, read latency and init FSM encoding.
package slc3_mem_pkg;

  localparam logic [15:0] MMIO_SW_HEX_ADDR = 16'hFFFF;
  localparam int          RD_LATENCY       = 2;

  typedef enum logic [1:0] {
    INIT_FILL,
    INIT_LAST,
    READY
  } init_state_t;

  function automatic logic is_mmio(input logic [15:0] addr);
    return addr == MMIO_SW_HEX_ADDR;
  endfunction

endpackage

// File: rtl/slc3_bram.sv
// Single-port synchronous RAM: read address registered on issue, data registered one cycle later.
// Two-cycle read latency, no backpressure; the array itself is never reset.
module slc3_bram
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH_BITS = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [DEPTH_BITS-1:0] i_addr,
  input  logic [15:0]           i_wdata,
  output logic [15:0]           o_rdata
);

  logic [15:0]           r_mem [0:(1<<DEPTH_BITS)-1];
  logic [DEPTH_BITS-1:0] r_raddr;
  logic                  r_re1;
  logic [15:0]           r_rdata;

  always_ff @(posedge Clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_raddr <= i_addr;
  end

  // Output register only moves on a real RAM read so the CPU-side data holds between reads.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_re1   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_re1 <= i_re;
      if (r_re1) r_rdata <= r_mem[r_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/slc3_mem_responder.sv
// SLC-3 memory responder: ROM preload, RAM reads/writes and the SW/HEX port at xFFFF.
// Reads return 2 cycles after issue at one per cycle; requests are dropped while preloading.
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int DEPTH_BITS = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Mem_OE,
  input  logic                  Mem_WE,
  input  logic [15:0]           ADDR,
  input  logic [15:0]           Data_from_CPU,
  output logic [15:0]           Data_to_CPU,
  output logic                  Rd_valid,
  input  logic [15:0]           SW,
  output logic [15:0]           HEX_Data,
  output logic [DEPTH_BITS-1:0] Rom_addr,
  input  logic [15:0]           Rom_data,
  output logic                  Init_busy
);

  init_state_t           r_state, w_state_nxt;
  logic [DEPTH_BITS-1:0] r_cnt, w_cnt_nxt;
  logic                  w_busy;
  logic                  w_ram_we;
  logic [DEPTH_BITS-1:0] w_ram_addr;
  logic [15:0]           w_ram_wdata;
  logic [15:0]           w_ram_rdata;
  logic                  w_is_mmio;
  logic                  w_cpu_we;
  logic                  w_issue;

  logic                  r_v1, r_v2;
  logic                  r_is_sw1, r_is_sw2;
  logic [15:0]           r_sw1, r_sw2;
  logic [15:0]           r_hex;

  assign w_is_mmio = is_mmio(ADDR);
  assign w_cpu_we  = Mem_WE & ~w_busy;
  assign w_issue   = Mem_OE & ~Mem_WE & ~w_busy;

  // ROM data lags its address by a cycle, so FILL writes slot cnt-1 and LAST mops up the top slot.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b1;
    w_ram_we    = 1'b0;
    w_ram_addr  = ADDR[DEPTH_BITS-1:0];
    w_ram_wdata = Rom_data;
    case (r_state)
      INIT_FILL: begin
        w_cnt_nxt  = r_cnt + DEPTH_BITS'(1);
        w_ram_we   = (r_cnt != '0);
        w_ram_addr = r_cnt - DEPTH_BITS'(1);
        if (r_cnt == '1) w_state_nxt = INIT_LAST;
      end
      INIT_LAST: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = '1;
        w_state_nxt = READY;
      end
      READY: begin
        w_busy      = 1'b0;
        w_ram_we    = Mem_WE & ~w_is_mmio;
        w_ram_wdata = Data_from_CPU;
      end
      default: w_state_nxt = INIT_FILL;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= INIT_FILL;
      r_cnt    <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_is_sw2 <= 1'b0;
      r_sw2    <= '0;
      r_hex    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_v1    <= w_issue;
      r_v2    <= r_v1;
      if (w_issue) begin
        r_is_sw1 <= w_is_mmio;
        r_sw1    <= SW;
      end
      if (r_v1) begin
        r_is_sw2 <= r_is_sw1;
        r_sw2    <= r_sw1;
      end
      if (w_cpu_we && w_is_mmio) r_hex <= Data_from_CPU;
    end
  end

  slc3_bram #(.DEPTH_BITS(DEPTH_BITS)) u_bram (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_we    (w_ram_we),
    .i_re    (w_issue & ~w_is_mmio),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign Data_to_CPU = r_is_sw2 ? r_sw2 : w_ram_rdata;
  assign Rd_valid    = r_v2;
  assign HEX_Data    = r_hex;
  assign Rom_addr    = r_cnt;
  assign Init_busy   = w_busy;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: queue-based reference model checked every cycle plus directed literal checks.
module tb_slc3_mem_responder;
  import slc3_mem_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Mem_OE = 1'b0;
  logic        Mem_WE = 1'b0;
  logic [15:0] ADDR = '0;
  logic [15:0] Data_from_CPU = '0;
  logic [15:0] SW = '0;
  logic [15:0] Rom_data = '0;
  logic [15:0] Data_to_CPU;
  logic        Rd_valid;
  logic [15:0] HEX_Data;
  logic [7:0]  Rom_addr;
  logic        Init_busy;

  int n_tests = 0;
  int n_fail  = 0;

  slc3_mem_responder #(.DEPTH_BITS(8)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Mem_OE        (Mem_OE),
    .Mem_WE        (Mem_WE),
    .ADDR          (ADDR),
    .Data_from_CPU (Data_from_CPU),
    .Data_to_CPU   (Data_to_CPU),
    .Rd_valid      (Rd_valid),
    .SW            (SW),
    .HEX_Data      (HEX_Data),
    .Rom_addr      (Rom_addr),
    .Rom_data      (Rom_data),
    .Init_busy     (Init_busy)
  );

  always #5 Clk = ~Clk;

  // Init ROM: contents k ^ x00A5, data one cycle after address.
  always @(posedge Clk) Rom_data <= {8'h00, Rom_addr} ^ 16'h00A5;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: init cycle count, word array, HEX register and a queue of reads with due cycles.
  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;

  logic [15:0] ram_m [0:255];
  logic [15:0] exp_hex = '0;
  logic [15:0] exp_data = '0;
  logic        exp_valid = 1'b0;
  logic        exp_busy = 1'b1;
  logic        started = 1'b0;
  int          m_cnt = 0;
  int          g = 0;
  rd_t         pend[$];

  initial forever begin
    rd_t r;
    @(posedge Clk);
    if (Reset) begin
      started   = 1'b1;
      m_cnt     = 0;
      pend.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_hex   = '0;
    end else if (m_cnt < 257) begin
      if (m_cnt == 256)
        for (int k = 0; k < 256; k++) ram_m[k] = 16'(k) ^ 16'h00A5;
      m_cnt++;
    end else if (Mem_WE) begin
      if (ADDR == 16'hFFFF) exp_hex = Data_from_CPU;
      else ram_m[ADDR[7:0]] = Data_from_CPU;
    end else if (Mem_OE) begin
      r.due  = g + RD_LATENCY;
      r.data = (ADDR == 16'hFFFF) ? SW : ram_m[ADDR[7:0]];
      pend.push_back(r);
    end
    g++;
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == g) begin
      exp_valid = 1'b1;
      exp_data  = pend[0].data;
      void'(pend.pop_front());
    end
    exp_busy = (m_cnt < 257);
  end

  initial forever begin
    @(negedge Clk);
    if (started) begin
      chk("mdl_busy", {15'd0, Init_busy}, {15'd0, exp_busy});
      chk("mdl_rd_valid", {15'd0, Rd_valid}, {15'd0, exp_valid});
      chk("mdl_data", Data_to_CPU, exp_data);
      chk("mdl_hex", HEX_Data, exp_hex);
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Mem_OE = 1'b0;
    Mem_WE = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    Mem_WE = 1'b1;
    Mem_OE = 1'b0;
    ADDR = a;
    Data_from_CPU = d;
    step();
    idle();
  endtask

  task automatic read_chk(input logic [15:0] a, input logic [15:0] exp, input string nm);
    Mem_OE = 1'b1;
    Mem_WE = 1'b0;
    ADDR = a;
    step();
    idle();
    chk({nm, "_early_valid"}, {15'd0, Rd_valid}, 16'd0);
    step();
    chk({nm, "_valid"}, {15'd0, Rd_valid}, 16'd1);
    chk(nm, Data_to_CPU, exp);
  endtask

  // Counts busy cycles while poking strobes that must be ignored.
  task automatic count_init(output int n);
    n = 0;
    while (Init_busy === 1'b1 && n < 400) begin
      if (n == 10) begin
        Mem_OE = 1'b1; ADDR = 16'h0000;
      end else if (n == 20) begin
        Mem_WE = 1'b1; ADDR = 16'hFFFF; Data_from_CPU = 16'h5555;
      end else begin
        idle();
      end
      n++;
      step();
    end
    idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    Reset = 1'b1;
    step();
    step();
    chk("rst_busy", {15'd0, Init_busy}, 16'd1);
    chk("rst_valid", {15'd0, Rd_valid}, 16'd0);
    chk("rst_data", Data_to_CPU, 16'h0000);
    chk("rst_hex", HEX_Data, 16'h0000);
    chk("rst_rom_addr", {8'd0, Rom_addr}, 16'd0);

    Reset = 1'b0;
    count_init(n);
    chk("init_len", 16'(n), 16'd257);
    chk("init_hex_untouched", HEX_Data, 16'h0000);

    read_chk(16'h0000, 16'h00A5, "rd_0000");
    read_chk(16'h00FF, 16'h005A, "rd_00ff");

    Mem_OE = 1'b1;
    ADDR = 16'h0010;
    step();
    step();
    chk("ctl_c3_data", Data_to_CPU, 16'h00B5);
    chk("ctl_c3_valid", {15'd0, Rd_valid}, 16'd1);
    step();
    idle();
    chk("ctl_c4_valid", {15'd0, Rd_valid}, 16'd1);
    step();
    chk("ctl_c5_valid", {15'd0, Rd_valid}, 16'd1);
    chk("ctl_c5_data", Data_to_CPU, 16'h00B5);
    step();
    chk("ctl_c6_valid", {15'd0, Rd_valid}, 16'd0);

    wr(16'hFFFF, 16'h1234);
    chk("hex_1234", HEX_Data, 16'h1234);
    read_chk(16'h00FF, 16'h005A, "ram_ff_untouched");

    SW = 16'hBEEF;
    Mem_OE = 1'b1;
    ADDR = 16'hFFFF;
    step();
    idle();
    SW = 16'h0000;
    step();
    chk("sw_valid", {15'd0, Rd_valid}, 16'd1);
    chk("sw_data", Data_to_CPU, 16'hBEEF);
    chk("sw_read_no_hex", HEX_Data, 16'h1234);
    step();
    chk("sw_hold", Data_to_CPU, 16'hBEEF);

    wr(16'h0020, 16'hCAFE);
    read_chk(16'h0020, 16'hCAFE, "raw_0020");

    Mem_OE = 1'b1;
    Mem_WE = 1'b1;
    ADDR = 16'h0021;
    Data_from_CPU = 16'h1111;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("oewe_no_valid", {15'd0, Rd_valid}, 16'd0);
      step();
    end
    read_chk(16'h0021, 16'h1111, "oewe_written");

    wr(16'h0105, 16'h7777);
    read_chk(16'h0005, 16'h7777, "alias_0005");

    Mem_OE = 1'b1;
    ADDR = 16'h0005;
    step();
    idle();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("inflight_dropped", {15'd0, Rd_valid}, 16'd0);
    n = 0;
    while (Rom_addr != 8'd100 && n < 400) begin
      n++;
      step();
    end
    chk("reach_cnt100", {8'd0, Rom_addr}, 16'd100);
    Reset = 1'b1;
    step();
    chk("midinit_rom_addr", {8'd0, Rom_addr}, 16'd0);
    chk("midinit_busy", {15'd0, Init_busy}, 16'd1);
    Reset = 1'b0;
    count_init(n);
    chk("init_len_rerun", 16'(n), 16'd257);
    read_chk(16'h0005, 16'h00A0, "reinit_0005");
    read_chk(16'h0020, 16'h0085, "reinit_0020");

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
